// File: rtl/tk_pkg.sv
// Shared types, limits and the hour display conversion for the timekeeper.
package tk_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [5:0] SEC_MAX      = 6'd59;
    localparam bcd_t       MIN_TENS_MAX = 4'd5;
    localparam bcd_t       BCD_MAX      = 4'd9;
    localparam logic [4:0] HR_MAX       = 5'd23;

    // Convert the binary 0-23 internal hour to two BCD display digits.
    // In 12-hour mode 0 shows as 12 and 13-23 fold down to 1-11.
    function automatic logic [7:0] hr_to_disp(input logic [4:0] hour, input logic mode12);
        logic [4:0] h;
        bcd_t       tens;
        bcd_t       ones;
        if (mode12) begin
            if (hour == 5'd0) begin
                h = 5'd12;
            end else if (hour > 5'd12) begin
                h = hour - 5'd12;
            end else begin
                h = hour;
            end
        end else begin
            h = hour;
        end
        // 20 mod 16 is 4 and 10 mod 16 wraps, so the low nibble gives the ones digit directly
        if (h >= 5'd20) begin
            tens = 4'd2;
            ones = h[3:0] - 4'd4;
        end else if (h >= 5'd10) begin
            tens = 4'd1;
            ones = h[3:0] - 4'd10;
        end else begin
            tens = 4'd0;
            ones = h[3:0];
        end
        return {tens, ones};
    endfunction

endpackage

// File: rtl/tk_divider.sv
// Seconds prescaler: counts clock cycles and emits a one-cycle tick enable.
module tk_divider #(
    parameter int DIV_NORMAL = 7999999,
    parameter int DIV_FAST   = 399,
    parameter int DIV_W      = 23
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic fast,
    input  logic clr,
    output logic tick
);

    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_next_s;
    logic [DIV_W-1:0] lim_s;
    logic             tick_r;
    logic             tick_next_s;

    // Next divider value; ">=" lets a switch to the shorter period wrap at once.
    always_comb begin
        div_next_s  = div_r;
        tick_next_s = 1'b0;
        lim_s       = fast ? DIV_W'(DIV_FAST) : DIV_W'(DIV_NORMAL);
        if (clr) begin
            div_next_s  = {DIV_W{1'b0}};
            tick_next_s = 1'b0;
        end else if (run) begin
            if (div_r >= lim_s) begin
                div_next_s  = {DIV_W{1'b0}};
                tick_next_s = 1'b1;
            end else begin
                div_next_s  = div_r + DIV_W'(1);
                tick_next_s = 1'b0;
            end
        end else begin
            div_next_s  = div_r;
            tick_next_s = 1'b0;
        end
    end

    // Divider and tick registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r  <= {DIV_W{1'b0}};
            tick_r <= 1'b0;
        end else begin
            div_r  <= div_next_s;
            tick_r <= tick_next_s;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/clock_timekeeper.sv
// Time-of-day core: h:m:s counters, set pulses, 12/24-hour display and daily alarm.
module clock_timekeeper
    import tk_pkg::*;
#(
    parameter int DIV_NORMAL       = 7999999,
    parameter int DIV_FAST         = 399,
    parameter int DIV_W            = 23,
    parameter bit ALARM_EN_DEFAULT = 1'b0
) (
    input  logic       pCLK,
    input  logic       nRST,
    input  logic       run,
    input  logic       fast,
    input  logic       mode12,
    input  logic       inc_min,
    input  logic       inc_hr,
    input  logic       alarm_arm,
    input  logic [4:0] alarm_hr,
    input  logic [5:0] alarm_min,
    output logic [5:0] sec,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] hr_tens,
    output logic [3:0] hr_ones,
    output logic       pm,
    output logic       tick,
    output logic       alarm_hit
);

    logic       tick_s;
    logic [5:0] sec_r,       sec_next_s;
    bcd_t       min_tens_r,  min_tens_next_s;
    bcd_t       min_ones_r,  min_ones_next_s;
    logic [4:0] hr_r,        hr_next_s;
    logic       arm_r;
    logic       alarm_hit_r, alarm_hit_next_s;
    bcd_t       min_tens_inc_s;
    bcd_t       min_ones_inc_s;
    logic       min_wrap_s;
    logic [4:0] hr_inc_s;
    logic [5:0] min_bin_s;

    tk_divider #(
        .DIV_NORMAL (DIV_NORMAL),
        .DIV_FAST   (DIV_FAST),
        .DIV_W      (DIV_W)
    ) u_divider (
        .clk   (pCLK),
        .rst_n (nRST),
        .run   (run),
        .fast  (fast),
        .clr   (inc_min),
        .tick  (tick_s)
    );

    // Incremented minute and hour candidates shared by counting and setting.
    always_comb begin
        min_wrap_s = (min_tens_r == MIN_TENS_MAX) && (min_ones_r == BCD_MAX);
        if (min_ones_r == BCD_MAX) begin
            min_ones_inc_s = 4'd0;
            if (min_tens_r == MIN_TENS_MAX) begin
                min_tens_inc_s = 4'd0;
            end else begin
                min_tens_inc_s = min_tens_r + 4'd1;
            end
        end else begin
            min_ones_inc_s = min_ones_r + 4'd1;
            min_tens_inc_s = min_tens_r;
        end
        hr_inc_s = (hr_r == HR_MAX) ? 5'd0 : hr_r + 5'd1;
    end

    // Next time: inc_min overrides a tick; inc_hr overrides any tick carry into hours.
    always_comb begin
        sec_next_s      = sec_r;
        min_tens_next_s = min_tens_r;
        min_ones_next_s = min_ones_r;
        if (inc_min) begin
            sec_next_s      = 6'd0;
            min_tens_next_s = min_tens_inc_s;
            min_ones_next_s = min_ones_inc_s;
        end else if (tick_s) begin
            if (sec_r == SEC_MAX) begin
                sec_next_s      = 6'd0;
                min_tens_next_s = min_tens_inc_s;
                min_ones_next_s = min_ones_inc_s;
            end else begin
                sec_next_s = sec_r + 6'd1;
            end
        end else begin
            sec_next_s = sec_r;
        end
        if (inc_hr) begin
            hr_next_s = hr_inc_s;
        end else if (tick_s && !inc_min && (sec_r == SEC_MAX) && min_wrap_s) begin
            hr_next_s = hr_inc_s;
        end else begin
            hr_next_s = hr_r;
        end
    end

    // Alarm fires only when a plain tick lands exactly on alarm_hr:alarm_min:00.
    always_comb begin
        min_bin_s = 6'(min_tens_next_s) * 6'd10 + 6'(min_ones_next_s);
        if (arm_r && tick_s && !inc_min && !inc_hr && (sec_next_s == 6'd0) &&
            (min_bin_s == alarm_min) && (hr_next_s == alarm_hr)) begin
            alarm_hit_next_s = 1'b1;
        end else begin
            alarm_hit_next_s = 1'b0;
        end
    end

    // Time, arm and alarm registers.
    always_ff @(posedge pCLK or negedge nRST) begin
        if (!nRST) begin
            sec_r       <= 6'd0;
            min_tens_r  <= 4'd0;
            min_ones_r  <= 4'd0;
            hr_r        <= 5'd0;
            arm_r       <= ALARM_EN_DEFAULT;
            alarm_hit_r <= 1'b0;
        end else begin
            sec_r       <= sec_next_s;
            min_tens_r  <= min_tens_next_s;
            min_ones_r  <= min_ones_next_s;
            hr_r        <= hr_next_s;
            arm_r       <= alarm_arm;
            alarm_hit_r <= alarm_hit_next_s;
        end
    end

    assign sec                = sec_r;
    assign min_tens           = min_tens_r;
    assign min_ones           = min_ones_r;
    assign {hr_tens, hr_ones} = hr_to_disp(hr_r, mode12);
    assign pm                 = (hr_r >= 5'd12);
    assign tick               = tick_s;
    assign alarm_hit          = alarm_hit_r;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Randomised and directed bench for clock_timekeeper against a seconds-of-day model.
module tb_clock_timekeeper;

    localparam int LIM_N = 59;
    localparam int LIM_F = 399;

    logic       pCLK = 1'b0;
    logic       nRST = 1'b0;
    logic       run = 1'b0, fast = 1'b0, mode12 = 1'b0;
    logic       inc_min = 1'b0, inc_hr = 1'b0, alarm_arm = 1'b0;
    logic [4:0] alarm_hr = 5'd0;
    logic [5:0] alarm_min = 6'd0;
    logic [5:0] sec;
    logic [3:0] min_tens, min_ones, hr_tens, hr_ones;
    logic       pm, tick, alarm_hit;

    clock_timekeeper #(
        .DIV_NORMAL (LIM_N), .DIV_FAST (LIM_F), .DIV_W (23), .ALARM_EN_DEFAULT (1'b0)
    ) dut (
        .pCLK (pCLK), .nRST (nRST), .run (run), .fast (fast), .mode12 (mode12),
        .inc_min (inc_min), .inc_hr (inc_hr), .alarm_arm (alarm_arm),
        .alarm_hr (alarm_hr), .alarm_min (alarm_min),
        .sec (sec), .min_tens (min_tens), .min_ones (min_ones),
        .hr_tens (hr_tens), .hr_ones (hr_ones), .pm (pm), .tick (tick), .alarm_hit (alarm_hit)
    );

    always #5 pCLK = ~pCLK;

    int n_vec = 0;
    int n_err = 0;

    // reference model: time kept as seconds since midnight
    int m_div  = 0;
    int m_sod  = 0;
    bit m_tick = 1'b0;
    bit m_hit  = 1'b0;
    bit m_arm  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int disp_hr(input int h, input bit m12);
        if (!m12) return h;
        return (h % 12 == 0) ? 12 : h % 12;
    endfunction

    task automatic model_reset();
        m_div = 0; m_sod = 0; m_tick = 1'b0; m_hit = 1'b0; m_arm = 1'b0;
    endtask

    task automatic model_update();
        int lim, ndiv, nsod, h_old, mn_old;
        bit ntick;
        lim = fast ? LIM_F : LIM_N;
        if (inc_min) begin ndiv = 0; ntick = 1'b0; end
        else if (run) begin
            if (m_div >= lim) begin ndiv = 0; ntick = 1'b1; end
            else begin ndiv = m_div + 1; ntick = 1'b0; end
        end else begin ndiv = m_div; ntick = 1'b0; end
        h_old  = m_sod / 3600;
        mn_old = (m_sod / 60) % 60;
        if (inc_min)     nsod = h_old * 3600 + ((mn_old + 1) % 60) * 60;
        else if (m_tick) nsod = (m_sod + 1) % 86400;
        else             nsod = m_sod;
        if (inc_hr) nsod = ((h_old + 1) % 24) * 3600 + nsod % 3600;
        m_hit  = m_arm && m_tick && !inc_min && !inc_hr && (alarm_hr < 24) && (alarm_min < 60) &&
                 (nsod == int'(alarm_hr) * 3600 + int'(alarm_min) * 60);
        m_arm  = alarm_arm;
        m_div  = ndiv;
        m_tick = ntick;
        m_sod  = nsod;
    endtask

    task automatic check_outputs();
        int h, mn, s, dh;
        h  = m_sod / 3600;
        mn = (m_sod / 60) % 60;
        s  = m_sod % 60;
        dh = disp_hr(h, mode12);
        chk("sec", sec, s);
        chk("min_tens", min_tens, mn / 10);
        chk("min_ones", min_ones, mn % 10);
        chk("hr_tens", hr_tens, dh / 10);
        chk("hr_ones", hr_ones, dh % 10);
        chk("pm", pm, (h >= 12) ? 1 : 0);
        chk("tick", tick, m_tick);
        chk("alarm_hit", alarm_hit, m_hit);
    endtask

    task automatic step();
        model_update();
        @(posedge pCLK);
        @(negedge pCLK);
        check_outputs();
    endtask

    task automatic pulse_min();
        inc_min = 1'b1; step(); inc_min = 1'b0;
    endtask

    task automatic pulse_hr();
        inc_hr = 1'b1; step(); inc_hr = 1'b0;
    endtask

    // steps until tick is seen; n is the step count, budget+1 on timeout
    task automatic tick_wait(output int n, input int budget);
        n = budget + 1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (tick === 1'b1) begin n = i; break; end
        end
    endtask

    // set h:m with pulses (leaves sec=0), then run until the seconds reach s
    task automatic goto_time(input int h, input int mn, input int s);
        run = 1'b0;
        for (int i = 0; i < 30 && (m_sod / 3600) != h; i++) pulse_hr();
        for (int i = 0; i < 61; i++) begin
            pulse_min();
            if (((m_sod / 60) % 60) == mn) break;
        end
        run = 1'b1;
        for (int i = 0; i < 10000 && (m_sod % 60) != s; i++) step();
        chk("goto_time", m_sod, h * 3600 + mn * 60 + s);
    endtask

    initial begin
        int n, d, cnt;
        // reset state, in both display modes
        run = 1'b1; fast = 1'b1;
        model_reset();
        @(negedge pCLK);
        check_outputs();
        mode12 = 1'b1; #1;
        check_outputs();
        chk("reset_hr12", {hr_tens, hr_ones}, 8'h12);
        mode12 = 1'b0;
        @(negedge pCLK);
        nRST = 1'b1;

        // first tick 400 cycles after release, then every 400
        tick_wait(n, 1000);
        chk("first_tick", n, 400);
        step();
        chk("sec_after_tick", sec, 1);
        tick_wait(n, 1000);
        chk("tick_period", n + 1, 400);

        // midnight rollover, shown in 12-hour mode
        fast = 1'b0;
        goto_time(23, 59, 58);
        tick_wait(n, 200);
        tick_wait(n, 200);
        step();
        run = 1'b0; mode12 = 1'b1;
        step();
        chk("roll_hr", {hr_tens, hr_ones}, 8'h12);
        chk("roll_min", {min_tens, min_ones}, 8'h00);
        chk("roll_sec", sec, 0);
        chk("roll_pm", pm, 0);

        // hour 13 in both modes
        for (int i = 0; i < 13; i++) pulse_hr();
        chk("h13_12h", {hr_tens, hr_ones, 3'b000, pm}, {8'h01, 4'd1});
        mode12 = 1'b0;
        step();
        chk("h13_24h", {hr_tens, hr_ones}, 8'h13);
        chk("h13_time", {min_tens, min_ones, 2'b00, sec}, 16'h0000);

        // inc_min on the tick cycle at 10:59:30
        goto_time(10, 59, 30);
        tick_wait(n, 200);
        pulse_min();
        chk("incmin_tick", {hr_tens, hr_ones, min_tens, min_ones}, 16'h1000);
        chk("incmin_sec", sec, 0);
        tick_wait(n, 200);
        chk("incmin_div0", n, LIM_N + 1);

        // alarm at 07:30 reached by a tick
        alarm_arm = 1'b1; alarm_hr = 5'd7; alarm_min = 6'd30;
        goto_time(7, 29, 59);
        tick_wait(n, 200);
        step();
        chk("alarm_fire", alarm_hit, 1);
        step();
        chk("alarm_one_cycle", alarm_hit, 0);
        // reaching 07:30 by inc_min must not fire
        goto_time(7, 29, 0);
        run = 1'b0;
        pulse_min();
        step();
        chk("alarm_set_quiet", {alarm_hit, hr_ones, min_tens, min_ones}, {1'b0, 12'h730});

        // hold for 1000 cycles, then resume from the held divider
        run = 1'b1;
        for (int i = 0; i < 25; i++) step();
        run = 1'b0;
        d = m_div;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (tick === 1'b1) cnt++;
        end
        chk("hold_ticks", cnt, 0);
        run = 1'b1;
        tick_wait(n, 200);
        chk("resume_div", n, LIM_N - d + 1);

        // randomised traffic with an asynchronous reset in the middle
        for (int c = 0; c < 8000; c++) begin
            run     = ($urandom % 8) != 0;
            inc_min = ($urandom % 40) == 0;
            inc_hr  = ($urandom % 50) == 0;
            if ($urandom % 200 == 0) fast = ~fast;
            if ($urandom % 50 == 0) mode12 = ~mode12;
            if ($urandom % 300 == 0) alarm_arm = ~alarm_arm;
            if (c % 700 == 0) begin
                case ($urandom % 3)
                    0: begin
                        alarm_hr  = 5'(m_sod / 3600);
                        alarm_min = 6'(((m_sod / 60) % 60 + 1) % 60);
                    end
                    1: begin
                        alarm_hr  = 5'($urandom_range(24, 31));
                        alarm_min = 6'($urandom_range(0, 63));
                    end
                    default: begin
                        alarm_hr  = 5'($urandom_range(0, 23));
                        alarm_min = 6'($urandom_range(60, 63));
                    end
                endcase
                alarm_arm = 1'b1;
            end
            step();
            if (c == 4000) begin
                #2 nRST = 1'b0;
                #1 model_reset();
                check_outputs();
                @(negedge pCLK);
                nRST = 1'b1;
            end
        end
        inc_min = 1'b0; inc_hr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
